// File: rtl/sram_reader_pkg.sv
// ---------------------------------------------------------------------------
// sram_reader_pkg
//
// Shared definitions for the SRAM burst reader:
//   - default geometry of the dual-port block RAM (address/data width, depth)
//   - depth and count width of the skid FIFO that absorbs the RAM read latency
//   - controller FSM state encoding
//   - helper that qualifies a requested burst length
// ---------------------------------------------------------------------------
package sram_reader_pkg;

    localparam int ADDR_W_DEF = 3;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 8;

    // Two entries are enough: one word may sit in the buffer while a second
    // read is in flight, which is exactly what keeps an unstalled burst at
    // one word per cycle with a one-cycle registered RAM read.
    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // A burst must cover at least one word and no more than the whole RAM.
    function automatic logic len_legal(input int unsigned n, input int unsigned depth);
        return (n != 0) && (n <= depth);
    endfunction

endpackage

// File: rtl/sram_reader_skid.sv
// ---------------------------------------------------------------------------
// sram_reader_skid
//
// Two-entry synchronous FIFO holding RAM read data until the downstream
// stream accepts it.
//
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (FIFO empty, storage zeroed)
//   push   in   write data into the tail this cycle
//   data   in   word to write
//   pop    in   remove the head word this cycle
//   count  out  number of words held (0..2)
//   head   out  oldest word; zero after reset
//
// A pop on an empty FIFO is ignored. A push into a full FIFO is only taken
// when a pop frees a slot in the same cycle; the controller never relies on
// this, but it keeps the buffer self-consistent.
// ---------------------------------------------------------------------------
module sram_reader_skid
    import sram_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_W-1:0]     data,
    input  logic                  pop,
    output logic [FIFO_CNT_W-1:0] count,
    output logic [DATA_W-1:0]     head
);

    localparam logic [FIFO_CNT_W-1:0] FULL = FIFO_CNT_W'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic              wr_ptr;
    logic              rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL) || do_pop);

    // The head slot is never written while it holds a live word, so the
    // head stays stable for as long as the consumer stalls.
    assign head = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_burst_reader.sv
// ---------------------------------------------------------------------------
// sram_burst_reader
//
// Read-side controller for the dual-port block RAM. A start request launches
// a burst of sequential reads (address wraps modulo DEPTH); returned words are
// buffered in a 2-entry skid FIFO and presented as a valid/ready stream.
//
// Ports:
//   rd_clk     in   clock, shared with the RAM read port
//   rst_n      in   asynchronous active-low reset
//   start      in   burst request, sampled only while busy=0
//   base_addr  in   first address of the burst (sampled with start)
//   len        in   burst length 1..DEPTH (sampled with start; others ignored)
//   rd_en      out  RAM read enable
//   rd_addr    out  RAM read address
//   d_out      in   RAM read data, valid the cycle after rd_en
//   m_valid    out  stream word valid
//   m_data     out  stream word
//   m_ready    in   downstream accept
//   busy       out  burst in progress
//   done       out  one-cycle pulse the cycle after the final handshake
//   m_last     out  (only with SRAM_BURST_READER_LAST_EN defined) marks the
//                   final word of the burst while m_valid=1
//
// Stream handshake: a word transfers on every rising edge where m_valid and
// m_ready are both 1. Once m_valid rises it stays high and m_data stays
// unchanged until that transfer; m_valid never depends on m_ready, while
// m_ready may depend on m_valid.
//
// The FSM state is available as the internal signal `state` for checkers.
// ---------------------------------------------------------------------------
module sram_burst_reader
    import sram_reader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              rd_clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] d_out,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
`ifdef SRAM_BURST_READER_LAST_EN
    output logic              m_last,
`endif
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

    state_t                state;
    state_t                state_nxt;

    logic [ADDR_W-1:0]     addr_q;
    logic [ADDR_W:0]       issue_cnt;
    logic [ADDR_W:0]       deliv_cnt;
    logic                  inflight;
    logic                  done_q;

    logic [FIFO_CNT_W-1:0] fifo_count;
    logic [DATA_W-1:0]     fifo_head;

    logic                  load;
    logic                  issue;
    logic                  pop;
    logic                  final_pop;
    logic [2:0]            occupancy;

    // ---------------------------------------------------------------------
    // Shared decode
    // ---------------------------------------------------------------------
    assign m_valid = (fifo_count != '0);
    assign m_data  = fifo_head;
    assign pop     = m_valid && m_ready;

    // Words that will be buffered or in flight at the next edge if nothing
    // new is issued now. Allowing an issue only when this is <= 1 means the
    // FIFO plus the in-flight read never exceed the two skid entries. The
    // same-cycle pop is counted so a streaming burst never bubbles.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};

    assign load      = (state == IDLE) && start && len_legal(32'(len), 32'(DEPTH));
    assign issue     = (state == READ) && (issue_cnt != '0) && (occupancy <= 3'd1);
    assign final_pop = pop && (deliv_cnt == CNT_ONE);

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (load) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                if (issue && (issue_cnt == CNT_ONE)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (final_pop) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------------
    always_comb begin
        rd_en = 1'b0;
        busy  = 1'b0;
        case (state)
            IDLE: begin
                rd_en = 1'b0;
                busy  = 1'b0;
            end
            READ: begin
                rd_en = issue;
                busy  = 1'b1;
            end
            DRAIN: begin
                rd_en = 1'b0;
                busy  = 1'b1;
            end
            default: begin
                rd_en = 1'b0;
                busy  = 1'b0;
            end
        endcase
    end

    assign rd_addr = addr_q;
    assign done    = done_q;

`ifdef SRAM_BURST_READER_LAST_EN
    // The delivery counter reaches 1 exactly when the head is the last word.
    assign m_last = m_valid && (deliv_cnt == CNT_ONE);
`endif

    // ---------------------------------------------------------------------
    // Address, issue/delivery counters, in-flight flag and done pulse
    // ---------------------------------------------------------------------
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            issue_cnt <= '0;
            deliv_cnt <= '0;
            inflight  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            if (load) begin
                addr_q    <= base_addr;
                issue_cnt <= len;
                deliv_cnt <= len;
            end else begin
                if (issue) begin
                    // DEPTH is 2**ADDR_W, so the natural roll-over is the wrap.
                    addr_q    <= addr_q + 1'b1;
                    issue_cnt <= issue_cnt - 1'b1;
                end
                if (pop) begin
                    deliv_cnt <= deliv_cnt - 1'b1;
                end
            end
            inflight <= issue;
            done_q   <= (state == DRAIN) && final_pop;
        end
    end

    // ---------------------------------------------------------------------
    // Skid FIFO: every cycle with a read in flight, the RAM word is captured.
    // ---------------------------------------------------------------------
    sram_reader_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk   (rd_clk),
        .rst_n (rst_n),
        .push  (inflight),
        .data  (d_out),
        .pop   (pop),
        .count (fifo_count),
        .head  (fifo_head)
    );

endmodule

// File: tb/tb_sram_burst_reader.sv
// ---------------------------------------------------------------------------
// tb_sram_burst_reader
//
// Directed bench for sram_burst_reader. A behavioural RAM with a one-cycle
// registered read is preloaded with 0x10..0x17. Inputs change on the falling
// edge; outputs are sampled 1 ns later, well away from the rising edge.
// Cycle numbering: start is sampled at edge 0, cycle 1 follows that edge.
// Define SRAM_BURST_READER_LAST_EN to exercise m_last.
// ---------------------------------------------------------------------------
module tb_sram_burst_reader;

    logic       rd_clk    = 1'b0;
    logic       rst_n     = 1'b0;
    logic       start     = 1'b0;
    logic [2:0] base_addr = 3'd0;
    logic [3:0] len       = 4'd0;
    logic       rd_en;
    logic [2:0] rd_addr;
    logic [7:0] d_out     = 8'h00;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready   = 1'b0;
    logic       busy;
    logic       done;
`ifdef SRAM_BURST_READER_LAST_EN
    logic       m_last;
`endif

    int checks   = 0;
    int failures = 0;

    // Per-burst observations gathered by run_stream
    logic [7:0] got_q[$];
    logic [7:0] addr_seen[$];
    logic       lst_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp_addr_q[$];
    int first_valid_cyc;
    int last_hs_cyc;
    int done_cyc;
    int done_cnt;
    int stab_err;
    int rule_err;

    logic [7:0] ram [8];

    // ---------------- clock / reset ----------------
    always #5 rd_clk = ~rd_clk;

    // Behavioural RAM read port: one-cycle registered read.
    always @(posedge rd_clk) begin
        if (rd_en) d_out <= ram[rd_addr];
    end

    sram_burst_reader dut (
        .rd_clk    (rd_clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .d_out     (d_out),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready),
`ifdef SRAM_BURST_READER_LAST_EN
        .m_last    (m_last),
`endif
        .busy      (busy),
        .done      (done)
    );

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_q(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
        logic [7:0] g;
        check({tag, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            g = (i < got.size()) ? got[i] : 8'hxx;
            check($sformatf("%s[%0d]", tag, i), {24'd0, g}, {24'd0, exp[i]});
        end
    endtask

    // Expected words and addresses for a burst, from the RAM preload.
    task automatic build_exp(input int b, input int n);
        exp_q.delete();
        exp_addr_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(8'((b + i) % 8));
            exp_q.push_back(8'h10 + 8'((b + i) % 8));
        end
    endtask

    // ---------------- driver / monitor ----------------
    // Caller raises start just before edge 0. mode 0: m_ready held 1;
    // mode 1: m_ready follows 1,0,0,1 repeating. restart_cyc>0 raises a
    // competing start (base 5, len 8) in that cycle. Returns on done or when
    // the cycle budget expires.
    task automatic run_stream(input int mode, input int budget, input int restart_cyc);
        int         issued = 0;
        int         popped = 0;
        logic       prev_stall = 1'b0;
        logic [7:0] prev_data = 8'h00;
        logic       hs;
        got_q.delete();
        addr_seen.delete();
        lst_q.delete();
        first_valid_cyc = -1;
        last_hs_cyc     = -1;
        done_cyc        = -1;
        done_cnt        = 0;
        stab_err        = 0;
        rule_err        = 0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge rd_clk);
            start = (cyc == restart_cyc);
            if (cyc == restart_cyc) begin
                base_addr = 3'd5;
                len       = 4'd8;
            end
            m_ready = (mode == 0) ? 1'b1 : (((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3));
            #1;
            if (done) begin
                done_cyc = cyc;
                done_cnt++;
                break;
            end
            hs = m_valid && m_ready;
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_stall && (m_data !== prev_data)) stab_err++;
            if (rd_en) begin
                if ((issued - popped - int'(hs)) > 1) rule_err++;
                addr_seen.push_back({5'd0, rd_addr});
                issued++;
            end
            if (hs) begin
                got_q.push_back(m_data);
`ifdef SRAM_BURST_READER_LAST_EN
                lst_q.push_back(m_last);
`endif
                popped++;
                last_hs_cyc = cyc;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
        start = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        for (int i = 0; i < 8; i++) ram[i] = 8'h10 + 8'(i);

        // Reset state
        repeat (2) @(negedge rd_clk);
        #1;
        check("rst_rd_en",   {31'd0, rd_en},   32'd0);
        check("rst_rd_addr", {29'd0, rd_addr}, 32'd0);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_data",  {24'd0, m_data},  32'd0);
        check("rst_busy",    {31'd0, busy},    32'd0);
        check("rst_done",    {31'd0, done},    32'd0);
        @(negedge rd_clk);
        rst_n = 1'b1;

        // Full burst, no back-pressure: words in cycles 3..10, done in 11
        @(negedge rd_clk);
        start = 1'b1; base_addr = 3'd0; len = 4'd8;
        run_stream(0, 40, 0);
        build_exp(0, 8);
        cmp_q("full_data", got_q, exp_q);
        cmp_q("full_addr", addr_seen, exp_addr_q);
        check("full_first_valid", first_valid_cyc, 32'd3);
        check("full_last_hs",     last_hs_cyc,     32'd10);
        check("full_done_cyc",    done_cyc,        32'd11);
        check("full_busy_at_done", {31'd0, busy},  32'd0);

        // Start in the done cycle is accepted: single-word burst at 3
        start = 1'b1; base_addr = 3'd3; len = 4'd1;
        run_stream(0, 20, 0);
        build_exp(3, 1);
        cmp_q("one_data", got_q, exp_q);
        cmp_q("one_addr", addr_seen, exp_addr_q);
        check("one_first_valid", first_valid_cyc, 32'd3);
        check("one_done_cyc",    done_cyc,        32'd4);
`ifdef SRAM_BURST_READER_LAST_EN
        check("one_last_cnt", lst_q.size(), 32'd1);
        check("one_m_last", {31'd0, (lst_q.size() > 0) ? lst_q[0] : 1'bx}, 32'd1);
`endif

        // Address wrap: 6,7,0,1
        @(negedge rd_clk);
        start = 1'b1; base_addr = 3'd6; len = 4'd4;
        run_stream(0, 30, 0);
        build_exp(6, 4);
        cmp_q("wrap_data", got_q, exp_q);
        cmp_q("wrap_addr", addr_seen, exp_addr_q);
        check("wrap_done_cyc", done_cyc, 32'd7);

        // Back-pressure with m_ready 1,0,0,1,...
        @(negedge rd_clk);
        start = 1'b1; base_addr = 3'd0; len = 4'd8;
        run_stream(1, 100, 0);
        build_exp(0, 8);
        cmp_q("bp_data", got_q, exp_q);
        check("bp_stable",     stab_err, 32'd0);
        check("bp_issue_rule", rule_err, 32'd0);
        check("bp_done_cnt",   done_cnt, 32'd1);
        check("bp_done_after", done_cyc, last_hs_cyc + 1);
`ifdef SRAM_BURST_READER_LAST_EN
        check("bp_last_final", {31'd0, (lst_q.size() == 8) ? lst_q[7] : 1'bx}, 32'd1);
        check("bp_last_early", {31'd0, (lst_q.size() == 8) ? lst_q[6] : 1'bx}, 32'd0);
`endif

        // Start during a burst is ignored
        @(negedge rd_clk);
        start = 1'b1; base_addr = 3'd2; len = 4'd3;
        run_stream(0, 30, 2);
        build_exp(2, 3);
        cmp_q("ign_data", got_q, exp_q);
        cmp_q("ign_addr", addr_seen, exp_addr_q);
        check("ign_done_cyc", done_cyc, 32'd6);

        // Illegal lengths 0 and 9 are ignored
        @(negedge rd_clk);
        start = 1'b1; base_addr = 3'd1; len = 4'd0;
        @(negedge rd_clk);
        start = 1'b0;
        #1;
        check("len0_busy",  {31'd0, busy},  32'd0);
        check("len0_rd_en", {31'd0, rd_en}, 32'd0);
        @(negedge rd_clk);
        start = 1'b1; len = 4'd9;
        @(negedge rd_clk);
        start = 1'b0;
        #1;
        check("len9_busy",  {31'd0, busy},  32'd0);
        check("len9_rd_en", {31'd0, rd_en}, 32'd0);

        // Reset in cycle 5 of a len=8 burst
        @(negedge rd_clk);
        start = 1'b1; base_addr = 3'd0; len = 4'd8; m_ready = 1'b1;
        @(negedge rd_clk);
        start = 1'b0;
        repeat (3) @(negedge rd_clk);
        #1;
        check("pre_rst_m_valid", {31'd0, m_valid}, 32'd1);
        @(negedge rd_clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rd_en",   {31'd0, rd_en},   32'd0);
        check("mid_rst_rd_addr", {29'd0, rd_addr}, 32'd0);
        check("mid_rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("mid_rst_m_data",  {24'd0, m_data},  32'd0);
        check("mid_rst_busy",    {31'd0, busy},    32'd0);
        check("mid_rst_done",    {31'd0, done},    32'd0);
        repeat (2) @(negedge rd_clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge rd_clk);
            #1;
            if (done) done_cnt++;
        end
        check("post_rst_no_done", done_cnt, 32'd0);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        // Fresh burst after the abort
        @(negedge rd_clk);
        start = 1'b1; base_addr = 3'd4; len = 4'd2;
        run_stream(0, 30, 0);
        build_exp(4, 2);
        cmp_q("after_rst_data", got_q, exp_q);
        check("after_rst_done_cyc", done_cyc, 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_burst_reader.md
# sram_burst_reader

Read-side controller for the team's dual-port block RAM (8-bit words, 8 locations, one-cycle registered read). On a start request it issues a burst of sequential reads on the RAM's read port and presents the returned words as a valid/ready stream to downstream logic. A 2-entry skid buffer absorbs the RAM's fixed read latency, so back-pressure never loses a word and an unstalled burst streams at one word per cycle.

## Interface
- ADDR_W, 3: RAM address width.
- DATA_W, 8: RAM word width.
- DEPTH, 8: number of RAM words, equal to 2**ADDR_W.

Ports:
- rd_clk  in  1  single clock; the same clock as the RAM read port.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  burst request; sampled only while busy=0.
- base_addr  in  ADDR_W  first address of the burst; sampled with start.
- len  in  ADDR_W+1  burst length in words, 1..DEPTH; sampled with start.
- rd_en  out  1  RAM read enable.
- rd_addr  out  ADDR_W  RAM read address.
- d_out  in  DATA_W  RAM read data; valid one cycle after rd_en.
- m_valid  out  1  stream word valid.
- m_data  out  DATA_W  stream word.
- m_ready  in  1  downstream accept.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse after the final word handshake.

## Operation
- FSM states:
  - IDLE: start=1 with len in 1..DEPTH loads the address counter, the issue counter (len) and the delivery counter (len), then moves to READ. start=1 with len=0 or len>DEPTH is ignored and leaves the block in IDLE.
  - READ: issues reads. After the last read is issued, moves to DRAIN.
  - DRAIN: waits for the final handshake, then moves to IDLE and pulses done.
- Issue rule: rd_en=1 in READ only if (fifo_count + inflight − pop_this_cycle) ≤ 1. Here inflight is the rd_en registered from the previous cycle and pop is m_valid&m_ready.
- Each issue increments rd_addr modulo DEPTH (7 wraps to 0) and decrements the issue counter.
- Every cycle with inflight=1, d_out is pushed into the skid FIFO. The FIFO never overflows, by construction of the issue rule.
- m_valid = FIFO non-empty. m_data = FIFO head.
- m_data is held stable while m_valid=1 and m_ready=0.
- Each handshake decrements the delivery counter. The handshake that takes it to 0 ends the burst.
- start while busy=1 is ignored.
- Reset values: rd_en=0, rd_addr=0, m_valid=0, m_data=0, busy=0, done=0, FSM=IDLE, FIFO empty, counters 0.
- Reset asserted mid-burst aborts the burst immediately. An in-flight read is discarded, and no done pulse follows.

## Timing
- start sampled at edge 0. busy=1 from cycle 1. rd_en=1 with rd_addr=base_addr in cycle 1.
- d_out valid in cycle 2 and pushed at edge 2. m_valid=1 in cycle 3, so first-word latency is 3 cycles.
- With m_ready held at 1: one word per cycle, and the last word of an N-word burst appears in cycle N+2.
- done=1 and busy=0 in the cycle after the last handshake. A start in that same cycle is accepted.
- m_ready low for K cycles stalls issue after at most 2 words are buffered or in flight. Issue resumes in the cycle the stall releases.

## Configuration
- SRAM_BURST_READER_LAST_EN:
  - Defined: adds output m_last (1 bit), asserted with the final word of the burst while m_valid=1; reset value 0.
  - Undefined: the port and its logic are absent, and all other behaviour is identical.

## Structure
- Package sram_reader_pkg: FSM state enum (IDLE, READ, DRAIN), default ADDR_W/DATA_W/DEPTH constants, FIFO depth constant (2).
- One sub-module, sram_reader_skid: a 2-entry synchronous FIFO with push, pop, count, head, and asynchronous active-low reset.

## Test plan
- RAM preloaded with 0x10..0x17; start with base=0, len=8, m_ready=1:
  - Stream is 0x10..0x17 on consecutive cycles 3..10.
  - done pulses in cycle 11.
- Wrap: base=6, len=4:
  - rd_addr sequence is 6,7,0,1.
  - Data is 0x16,0x17,0x10,0x11.
- Back-pressure: base=0, len=8, m_ready toggling 1,0,0,1,...:
  - No word is lost or duplicated.
  - m_data stays stable while stalled.
  - rd_en is never high while 2 words are buffered or in flight.
- Illegal and ignored starts:
  - len=0 gives busy=0 and no rd_en.
  - A start during a burst does not alter rd_addr or the delivery count.
- Reset mid-burst: rst_n=0 in cycle 5 of a len=8 burst:
  - All outputs return to their reset values immediately.
  - No done pulse.
  - A new burst afterwards returns correct data.
- With SRAM_BURST_READER_LAST_EN defined, len=1:
  - m_last=1 with the single word.
  - done follows one cycle after its handshake.
